// File: rtl/capture_buffer.sv
// capture_buffer: drains an upstream FIFO into a 2**ADDR_W RAM; a pop reaches rd_valid 3 cycles later, pops stall at full.
// Define CAPTURE_BUFFER_OVERWRITE_EN to keep popping when full, discarding the oldest RAM entry and flagging overflow.
module capture_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              clr,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   RAM_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W+1:0] TOT_FULL = (ADDR_W + 2)'(DEPTH + 1);

  typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_HOLD} state_t;

  logic [DATA_W-1:0] r_ram [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_wr_pend;
  state_t            r_state;
  logic [DATA_W-1:0] r_rd_data;

  logic              w_hold;
  logic              w_fetch;
  logic              w_ram_avail;
  logic              w_ram_full;
  logic              w_drop;
  logic              w_inc;
  logic [ADDR_W+1:0] w_total;

  assign w_hold      = (r_state == S_HOLD);
  assign w_fetch     = (r_state == S_FETCH);
  assign count       = r_ram_cnt + {{ADDR_W{1'b0}}, w_hold};
  // the word popped last cycle is already committed, so it counts toward full
  assign w_total     = {1'b0, count} + {{(ADDR_W + 1){1'b0}}, r_wr_pend};
  assign full        = (w_total >= TOT_FULL);
  assign w_ram_avail = (r_ram_cnt != '0) || r_wr_pend;
  assign w_ram_full  = (r_ram_cnt == RAM_FULL);
  assign w_inc       = r_wr_pend && !w_drop;
  assign rd_valid    = w_hold;
  assign rd_data     = r_rd_data;

`ifdef CAPTURE_BUFFER_OVERWRITE_EN
  logic r_overflow;

  assign fifo_rd_en = !fifo_empty && !rst && !clr;
  // a fetch in the same cycle frees the slot, so only drop when nothing is leaving
  assign w_drop     = r_wr_pend && w_ram_full && !w_fetch;
  assign overflow   = r_overflow;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end
`else
  assign fifo_rd_en = !fifo_empty && !full && !rst && !clr;
  assign w_drop     = 1'b0;
  assign overflow   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (r_wr_pend && !rst && !clr) begin
      r_ram[r_wr_ptr] <= fifo_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_wr_pend <= 1'b0;
      r_state   <= S_EMPTY;
      r_rd_data <= '0;
    end else if (clr) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_wr_pend <= 1'b0;
      r_state   <= S_EMPTY;
    end else begin
      r_wr_pend <= fifo_rd_en;
      if (r_wr_pend) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_fetch || w_drop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      if (w_inc && !w_fetch) begin
        r_ram_cnt <= r_ram_cnt + (ADDR_W + 1)'(1);
      end else if (!w_inc && w_fetch) begin
        r_ram_cnt <= r_ram_cnt - (ADDR_W + 1)'(1);
      end
      unique case (r_state)
        S_EMPTY: if (w_ram_avail) r_state <= S_FETCH;
        S_FETCH: begin
          r_rd_data <= r_ram[r_rd_ptr];
          r_state   <= S_HOLD;
        end
        S_HOLD:  if (rd_ready) r_state <= w_ram_avail ? S_FETCH : S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Directed/random bench for capture_buffer (ADDR_W=2) against a queue-based scoreboard.
module tb_capture_buffer;

  localparam int DW = 32;
  localparam int AW = 2;
`ifdef CAPTURE_BUFFER_OVERWRITE_EN
  localparam int GAP = 4;
  logic [DW-1:0] ow_exp [5] = '{32'd1, 32'd5, 32'd6, 32'd7, 32'd8};
`else
  localparam int GAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          clr;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          full;
  logic          overflow;

  always #5 clk = ~clk;

  capture_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .clr        (clr),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .overflow   (overflow)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc_n = 0;
  int            n_rd = 0;
  int            first_pop = -1;
  int            first_vld = -1;
  int            fed = 0;
  bit            sb_on = 1'b1;
  logic [DW-1:0] src_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic feed(input logic [DW-1:0] w);
    src_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample at negedge, then apply the upstream FIFO response after the edge.
  task automatic cyc();
    logic          pop;
    logic          acc;
    logic          kill;
    logic [DW-1:0] w;
    @(negedge clk);
    cyc_n++;
    pop  = fifo_rd_en;
    acc  = rd_valid && rd_ready && !clr && !rst;
    kill = clr || rst;
    if (pop) chk("pop_vs_empty", 64'(fifo_empty), 64'(0));
    if (sb_on && rd_valid) begin
      chk("sb_have_entry", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
    end
    if (pop && first_pop < 0) first_pop = cyc_n;
    if (rd_valid && first_vld < 0) first_vld = cyc_n;
    if (acc) begin
      got_q.push_back(rd_data);
      n_rd++;
      if (exp_q.size() != 0) w = exp_q.pop_front();
    end
    @(posedge clk);
    #1;
    if (kill) exp_q.delete();
    if (pop && src_q.size() != 0) begin
      w = src_q.pop_front();
      fifo_dout = w;
      exp_q.push_back(w);
    end
    fifo_empty = (src_q.size() == 0);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; rd_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    run(3);
    chk("rst_fifo_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("rst_rd_valid",   64'(rd_valid),   64'(0));
    chk("rst_rd_data",    64'(rd_data),    64'(0));
    chk("rst_count",      64'(count),      64'(0));
    chk("rst_full",       64'(full),       64'(0));
    chk("rst_overflow",   64'(overflow),   64'(0));
    rst = 1'b0;

    // basic in-order delivery and pop-to-valid latency
    rd_ready = 1'b1; first_pop = -1; first_vld = -1; n_rd = 0;
    for (int i = 1; i <= 5; i++) feed(DW'(i));
    run(20);
    chk("t1_latency", 64'(first_vld - first_pop), 64'(3));
    chk("t1_reads", 64'(n_rd), 64'(5));
    for (int i = 0; i < 5; i++) chk("t1_seq", 64'(got_q[i]), 64'(i + 1));
    chk("t1_count", 64'(count), 64'(0));

    // fill with consumer stalled
    got_q.delete(); n_rd = 0; rd_ready = 1'b0;
`ifdef CAPTURE_BUFFER_OVERWRITE_EN
    sb_on = 1'b0;
`endif
    for (int i = 1; i <= 8; i++) feed(DW'(i));
    run(12);
`ifndef CAPTURE_BUFFER_OVERWRITE_EN
    chk("t2_count", 64'(count), 64'(5));
    chk("t2_full", 64'(full), 64'(1));
    chk("t2_overflow", 64'(overflow), 64'(0));
    chk("t2_stalled", 64'(fifo_rd_en), 64'(0));
    chk("t2_src_left", 64'(src_q.size()), 64'(3));
    rd_ready = 1'b1;
    run(40);
    chk("t2_reads", 64'(n_rd), 64'(8));
    for (int i = 0; i < 8; i++) chk("t2_seq", 64'(got_q[i]), 64'(i + 1));
    chk("t2_count_end", 64'(count), 64'(0));
`else
    chk("t2_overflow", 64'(overflow), 64'(1));
    chk("t2_count", 64'(count), 64'(5));
    chk("t2_src_left", 64'(src_q.size()), 64'(0));
    rd_ready = 1'b1;
    run(30);
    chk("t2_reads", 64'(n_rd), 64'(5));
    for (int i = 0; i < 5; i++) chk("t2_seq", 64'(got_q[i]), 64'(ow_exp[i]));
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t2_clr_overflow", 64'(overflow), 64'(0));
    sb_on = 1'b1;
`endif

    // long stream, consumer ready every other cycle, pointers wrap many times
    rd_ready = 1'b0; got_q.delete(); n_rd = 0; fed = 0;
    for (int c = 0; c < 20000 && n_rd < 1024; c++) begin
      rd_ready = ((c % 2) == 0);
      if (fed < 1024 && src_q.size() < 2 && (c % GAP) == 0) begin
        feed($urandom);
        fed++;
      end
      cyc();
    end
    run(5);
    chk("t3_reads", 64'(n_rd), 64'(1024));
    chk("t3_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("t3_count", 64'(count), 64'(0));

    // clr with three stored and one pop in flight
    rd_ready = 1'b0; got_q.delete(); n_rd = 0;
    for (int i = 0; i < 4; i++) feed(DW'(32'h100 + i));
    for (int c = 0; c < 20 && count != 3; c++) cyc();
    chk("t4_count3", 64'(count), 64'(3));
    clr = 1'b1; rd_ready = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t4_clr_count", 64'(count), 64'(0));
    chk("t4_clr_rd_valid", 64'(rd_valid), 64'(0));
    chk("t4_clr_overflow", 64'(overflow), 64'(0));
    feed(32'hABCD0001);
    feed(32'hABCD0002);
    run(15);
    chk("t4_reads", 64'(n_rd), 64'(2));
    chk("t4_first_after_clr", 64'(got_q[0]), 64'(32'hABCD0001));

    // rst in the middle of traffic
    got_q.delete(); n_rd = 0; rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) feed($urandom);
    run(4);
    rst = 1'b1;
    cyc();
    chk("t5_fifo_rd_en", 64'(fifo_rd_en), 64'(0));
    chk("t5_rd_valid",   64'(rd_valid),   64'(0));
    chk("t5_rd_data",    64'(rd_data),    64'(0));
    chk("t5_count",      64'(count),      64'(0));
    chk("t5_full",       64'(full),       64'(0));
    chk("t5_overflow",   64'(overflow),   64'(0));
    rst = 1'b0;
    #3;
    chk("t5_pop_after_rst", 64'(fifo_rd_en), 64'(1));
    run(40);
    chk("t5_src_drained", 64'(src_q.size()), 64'(0));
    chk("t5_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("t5_count_end", 64'(count), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
